// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch front end, upstream of the IF/ID register. Owns the PC,
// issues word fetches to the instruction ROM over a req/ack handshake and
// presents {address, instruction, valid} to IF/ID. It honours the hazard-unit
// stall and takes branch/jump redirects from EX. Every output is registered.
//
// Parameters:
//   ADDR_W    - PC / ROM address width
//   DATA_W    - instruction width
//   RESET_PC  - PC after reset
//   NOP_INSTR - instr_out value when nothing valid is presented
//
// Ports:
//   clk            in   clock, all state on posedge
//   rst            in   asynchronous reset, active-high
//   stall_in       in   1 = IF/ID not enabled this cycle
//   redirect_valid in   branch/jump taken (one-cycle pulse)
//   redirect_pc    in   new fetch target
//   rom_req        out  fetch request to the ROM
//   rom_addr       out  fetch address, stable while rom_req=1 until ack
//   rom_ack        in   ROM response valid, rom_data valid the same cycle
//   rom_data       in   fetched instruction
//   addr_out       out  PC of the presented instruction
//   instr_out      out  presented instruction
//   valid_out      out  presented instruction is real
//   misalign_out   out  (FETCH_MISALIGN_CHECK_EN only) misaligned redirect seen
//
// Build option:
//   FETCH_MISALIGN_CHECK_EN - when defined, a redirect to a target with
//   non-zero low bits raises misalign_out and parks the unit in HALT until a
//   reset or an aligned redirect. When undefined the low two bits of the
//   redirect target are simply cleared.
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter int                 ADDR_W    = 32,
   parameter int                 DATA_W    = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
   parameter logic [DATA_W-1:0]  NOP_INSTR = 32'h00000013
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_in,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              rom_req,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic              rom_ack,
   input  logic [DATA_W-1:0] rom_data,
   output logic [ADDR_W-1:0] addr_out,
   output logic [DATA_W-1:0] instr_out,
   output logic              valid_out
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic              misalign_out
`endif
);

   // IDLE  : single settling cycle after reset release
   // REQ   : request for pc outstanding (rom_addr == pc)
   // HOLD  : a fetched word is parked because IF/ID was not free
   // DRAIN : a request abandoned by a redirect is still in flight; its
   //         response is thrown away
   // HALT  : misaligned redirect seen (only reachable with the check enabled)
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_HOLD  = 3'd2,
      S_DRAIN = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_plus4;
   logic [ADDR_W-1:0] target_pc;
   logic [ADDR_W-1:0] hold_addr;
   logic [DATA_W-1:0] hold_instr;
   logic              consumed;
   logic              slot_free;

   // The presented instruction leaves this cycle when IF/ID is enabled; the
   // output slot can accept a new word if it is empty or being emptied.
   assign consumed  = valid_out & ~stall_in;
   assign slot_free = ~valid_out | consumed;

   // Natural wrap at 2^ADDR_W.
   assign pc_plus4  = pc + ADDR_W'(4);

`ifdef FETCH_MISALIGN_CHECK_EN
   logic target_bad;
   assign target_pc  = redirect_pc;
   assign target_bad = (redirect_pc[1:0] != 2'b00);
`else
   // Word fetches only: the byte offset of a redirect target is dropped.
   assign target_pc  = redirect_pc & ~ADDR_W'(3);
`endif

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge value of its neighbours, matching the hardware.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         pc         <= RESET_PC;
         rom_req    <= 1'b0;
         rom_addr   <= RESET_PC;
         addr_out   <= '0;
         instr_out  <= NOP_INSTR;
         valid_out  <= 1'b0;
         // NOTE: the hold buffer is a pair of plain registers, so it is reset
         // like everything else; its contents only matter while in HOLD.
         hold_addr  <= '0;
         hold_instr <= NOP_INSTR;
`ifdef FETCH_MISALIGN_CHECK_EN
         misalign_out <= 1'b0;
`endif
      end else if (redirect_valid) begin
         // A redirect beats every other event this cycle: whatever is being
         // presented or held belongs to the wrong path.
         pc        <= target_pc;
         valid_out <= 1'b0;
         instr_out <= NOP_INSTR;
`ifdef FETCH_MISALIGN_CHECK_EN
         misalign_out <= target_bad;
         if (target_bad) begin
            state   <= S_HALT;
            rom_req <= 1'b0;
         end else
`endif
         if ((state == S_REQ || state == S_DRAIN) && !rom_ack) begin
            // The ROM already owns a request that cannot be withdrawn; keep
            // rom_addr stable and swallow its response before refetching.
            // A further redirect in DRAIN only updates pc above.
            state <= S_DRAIN;
         end else begin
            // Nothing in flight (or its response arrives right now and is
            // dropped): fetch the new target immediately.
            state    <= S_REQ;
            rom_req  <= 1'b1;
            rom_addr <= target_pc;
         end
      end else begin
         case (state)
            S_IDLE: begin
               state    <= S_REQ;
               rom_req  <= 1'b1;
               rom_addr <= pc;
            end

            S_REQ: begin
               if (rom_ack) begin
                  pc <= pc_plus4;
                  if (slot_free) begin
                     // Zero-wait ROM streams one instruction per cycle here.
                     addr_out  <= pc;
                     instr_out <= rom_data;
                     valid_out <= 1'b1;
                     rom_addr  <= pc_plus4;
                  end else begin
                     // IF/ID is stalled on the current word: park the new one
                     // and stop fetching. rom_addr is left untouched.
                     hold_addr  <= pc;
                     hold_instr <= rom_data;
                     rom_req    <= 1'b0;
                     state      <= S_HOLD;
                  end
               end else if (consumed) begin
                  valid_out <= 1'b0;
               end
            end

            S_HOLD: begin
               if (consumed) begin
                  addr_out  <= hold_addr;
                  instr_out <= hold_instr;
                  valid_out <= 1'b1;
                  rom_req   <= 1'b1;
                  rom_addr  <= pc;
                  state     <= S_REQ;
               end
            end

            S_DRAIN: begin
               // Discard the stale response, then fetch the redirect target.
               if (rom_ack) begin
                  rom_addr <= pc;
                  state    <= S_REQ;
               end
            end

`ifdef FETCH_MISALIGN_CHECK_EN
            S_HALT: begin
               // Only reset or an aligned redirect leaves HALT.
               rom_req   <= 1'b0;
               valid_out <= 1'b0;
            end
`endif

            default: begin
               state   <= S_IDLE;
               rom_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch front end of the RISC-V pipeline, upstream of the IF/ID register. It owns the PC, issues word fetches to the instruction ROM over a req/ack handshake, and presents {address, instruction, valid} to IF/ID. It respects the hazard-unit stall and accepts branch/jump redirects from EX.

Parameters:
ADDR_W, 32, PC / ROM address width
DATA_W, 32, instruction width
RESET_PC, 0, PC after reset
NOP_INSTR, 32'h00000013, instr_out value when no valid instruction (addi x0,x0,0)

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous reset, active-high
stall_in  in  1  from hazard detect unit; 1 = IF/ID not enabled this cycle
redirect_valid  in  1  branch/jump taken, one-cycle pulse
redirect_pc  in  ADDR_W  new fetch target
rom_req  out  1  fetch request to ROM
rom_addr  out  ADDR_W  fetch address, stable while rom_req=1 until ack
rom_ack  in  1  ROM response valid; rom_data valid same cycle
rom_data  in  DATA_W  fetched instruction
addr_out  out  ADDR_W  PC of presented instruction, to IF/ID addrIn
instr_out  out  DATA_W  presented instruction, to IF/ID dataIn
valid_out  out  1  presented instruction is real

Behaviour:
- Clock is clk; reset is rst, asynchronous, active-high.
- Reset values: pc=RESET_PC, state=IDLE, rom_req=0, rom_addr=RESET_PC, addr_out=0, instr_out=NOP_INSTR, valid_out=0, hold buffer empty.
- All outputs are registered.
- consumed = valid_out & ~stall_in. slot_free = ~valid_out | consumed.
- IDLE: one cycle after reset release, then to REQ with rom_req=1, rom_addr=pc.
- REQ: rom_req=1.
  - rom_ack & slot_free: addr_out<=pc, instr_out<=rom_data, valid_out<=1; pc<=pc+4, rom_addr<=pc+4, stay REQ.
  - This gives 1 instr/cycle with a zero-wait ROM.
  - rom_ack & ~slot_free: hold_addr<=pc, hold_instr<=rom_data; pc<=pc+4; rom_req<=0; go to HOLD.
  - No ack: outputs unchanged, except valid_out<=0 if consumed.
- HOLD: rom_req=0.
  - On consumed: addr_out/instr_out<=hold, valid_out<=1; go to REQ with rom_addr=pc.
- DRAIN: rom_req=1 with the stale address until ack.
  - The ack's data is discarded.
  - Then go to REQ with rom_addr=pc (the redirect target).
- Redirect has highest priority over every other event in the same cycle:
  - pc<=redirect_pc, valid_out<=0, instr_out<=NOP_INSTR, hold dropped.
  - From IDLE, HOLD, or REQ with rom_ack the same cycle: discard any response; go to REQ with rom_addr<=redirect_pc.
  - From REQ without ack: the request is outstanding and cannot be withdrawn; go to DRAIN.
  - In DRAIN: the newest redirect_pc overwrites pc; at most one discard.
- PC arithmetic: pc+4 modulo 2^ADDR_W; 0xFFFFFFFC wraps to 0.
- rom_ack while rom_req=0 is ignored.
- Stall never alters rom_addr or drops a held instruction.
- Reset asserted mid-request: all state returns to reset values immediately; the ROM must tolerate an abandoned request.

Optional Feature:
FETCH_MISALIGN_CHECK_EN
- Defined:
  - Adds output misalign_out (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 sets misalign_out=1 and enters HALT: rom_req=0, valid_out=0.
  - HALT is left only by reset or by a new redirect with an aligned target.
- Undefined:
  - No port is added.
  - redirect_pc[1:0] is forced to 0 before use.

Test Plan:
- Reset release, zero-wait ROM returning addr>>2, stall_in=0 -> valid_out rises 2 cycles after IDLE; addr_out 0,4,8,12 on consecutive cycles; instr_out 0,1,2,3.
- Steady stream, stall_in=1 for 3 cycles at addr 8 -> addr_out held at 8 for the stall; fetch of 12 parked in HOLD; rom_req=0; after release addr_out 12 then 16; no loss or duplication.
- ROM with 3-cycle latency, redirect_valid to 0x100 one cycle after req for 0x10 -> DRAIN; 0x10 data discarded; next rom_addr=0x100; addr_out=0x100 appears; 0x10 never appears.
- Redirect to 0x40 coinciding with rom_ack and stall_in=0 -> the ack's data is dropped; valid_out=0 next cycle; next rom_addr=0x40.
- RESET_PC=0xFFFFFFF8, zero-wait ROM -> addr_out 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- rst asserted while rom_req=1 awaiting ack -> same cycle rom_req=0, valid_out=0, instr_out=0x00000013; a late rom_ack is ignored.
